// File: rtl/scc_ram_arb_pkg.sv
// rtl/scc_ram_arb_pkg.sv - shared types and widths for the SCC RAM arbiter
//
// Purpose: arbiter state encoding, RAM bus widths and the latency counter
// width shared by the arbiter, its interface and its round-robin picker.
// Ports: none (package).

package scc_ram_arb_pkg;

    localparam int RAM_ADR_W = 21;
    localparam int RAM_DAT_W = 8;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Counter preload for a given RAM latency; the WAIT phase ends when the
    // counter reaches zero, so it spans exactly 'latency' cycles.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int latency);
        return LAT_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/scc_ram_arbiter_if.sv
// rtl/scc_ram_arbiter_if.sv - client and RAM bus bundle for the SCC RAM arbiter
//
// Purpose: groups both client request/ack ports and the external RAM port.
// Modports:
//   slave  - arbiter view: client requests and ramdbi in; acks, read data,
//            RAM command and busy out.
//   master - client/RAM-model view: the mirror image of slave.

interface scc_ram_arbiter_if;
    import scc_ram_arb_pkg::*;

    logic                 c0_req;
    logic                 c0_wrt;
    logic [RAM_ADR_W-1:0] c0_adr;
    logic [RAM_DAT_W-1:0] c0_dbo;
    logic                 c0_ack;
    logic [RAM_DAT_W-1:0] c0_dbi;

    logic                 c1_req;
    logic                 c1_wrt;
    logic [RAM_ADR_W-1:0] c1_adr;
    logic [RAM_DAT_W-1:0] c1_dbo;
    logic                 c1_ack;
    logic [RAM_DAT_W-1:0] c1_dbi;

    logic                 ramreq;
    logic                 ramwrt;
    logic [RAM_ADR_W-1:0] ramadr;
    logic [RAM_DAT_W-1:0] ramdbo;
    logic [RAM_DAT_W-1:0] ramdbi;

    logic                 busy;

    modport slave (
        input  c0_req, c0_wrt, c0_adr, c0_dbo,
        input  c1_req, c1_wrt, c1_adr, c1_dbo,
        input  ramdbi,
        output c0_ack, c0_dbi, c1_ack, c1_dbi,
        output ramreq, ramwrt, ramadr, ramdbo,
        output busy
    );

    modport master (
        output c0_req, c0_wrt, c0_adr, c0_dbo,
        output c1_req, c1_wrt, c1_adr, c1_dbo,
        output ramdbi,
        input  c0_ack, c0_dbi, c1_ack, c1_dbi,
        input  ramreq, ramwrt, ramadr, ramdbo,
        input  busy
    );

endinterface

// File: rtl/scc_ram_arb_rr.sv
// rtl/scc_ram_arb_rr.sv - two-way round-robin picker for the SCC RAM arbiter
//
// Purpose: chooses which client to serve next.
// Ports:
//   i_req[1:0]    - request level of client 1 / client 0
//   i_last_grant  - client served most recently
//   o_grant       - chosen client (0 or 1), meaningful when o_valid
//   o_valid       - at least one client is requesting

module scc_ram_arb_rr (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_grant = 1'b0;
        case (i_req)
            2'b01:   o_grant = 1'b0;
            2'b10:   o_grant = 1'b1;
            // Tie: the client that was not served last goes first.
            2'b11:   o_grant = ~i_last_grant;
            default: o_grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/scc_ram_arbiter.sv
// rtl/scc_ram_arbiter.sv - two-client round-robin arbiter/sequencer for the SCC RAM port
//
// Purpose: serialises client 0 (SCC cartridge wrapper) and client 1 (wave
// loader / debug port) onto one fixed-latency RAM port. The granted command
// is latched for the whole access; read data is returned per client together
// with a one-cycle ack.
// Parameters:
//   RAM_LATENCY - cycles from the ramreq cycle to the cycle ramdbi is valid (1..15)
// Ports:
//   clk21m - system clock
//   reset  - asynchronous, active-high
//   bus    - scc_ram_arbiter_if.slave: client requests/acks, RAM port, busy

module scc_ram_arbiter
    import scc_ram_arb_pkg::*;
#(
    parameter int RAM_LATENCY = 2
) (
    input  logic                    clk21m,
    input  logic                    reset,
    scc_ram_arbiter_if.slave        bus
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_load(RAM_LATENCY);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;

    // Holds the client being served from grant through DONE, and doubles as
    // the round-robin history between accesses. Resetting it to 1 lets
    // client 0 win the first tie.
    logic                 r_last_grant;

    logic                 r_cmd_wrt;
    logic [RAM_ADR_W-1:0] r_cmd_adr;
    logic [RAM_DAT_W-1:0] r_cmd_dbo;
    logic [LAT_CNT_W-1:0] r_lat_cnt;
    logic [RAM_DAT_W-1:0] r_c0_dbi;
    logic [RAM_DAT_W-1:0] r_c1_dbi;

    logic                 w_rr_grant;
    logic                 w_rr_valid;
    logic                 w_take;
    logic                 w_lat_done;

    scc_ram_arb_rr u_rr (
        .i_req        ({bus.c1_req, bus.c0_req}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_rr_grant),
        .o_valid      (w_rr_valid)
    );

    assign w_take     = (r_state == IDLE) && w_rr_valid;
    assign w_lat_done = (r_lat_cnt == '0);

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rr_valid) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (w_lat_done) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_cmd_wrt    <= 1'b0;
            r_cmd_adr    <= '0;
            r_cmd_dbo    <= '0;
            r_lat_cnt    <= '0;
            r_c0_dbi     <= '0;
            r_c1_dbi     <= '0;
        end else begin
            if (w_take) begin
                r_last_grant <= w_rr_grant;
                r_cmd_wrt    <= w_rr_grant ? bus.c1_wrt : bus.c0_wrt;
                r_cmd_adr    <= w_rr_grant ? bus.c1_adr : bus.c0_adr;
                r_cmd_dbo    <= w_rr_grant ? bus.c1_dbo : bus.c0_dbo;
            end

            if (r_state == ISSUE) begin
                r_lat_cnt <= LAT_LOAD;
            end else if ((r_state == WAIT) && !w_lat_done) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end

            // ramdbi is only valid in the last WAIT cycle; writes leave the
            // client's read-data register untouched.
            if ((r_state == WAIT) && w_lat_done && !r_cmd_wrt) begin
                if (r_last_grant) begin
                    r_c1_dbi <= bus.ramdbi;
                end else begin
                    r_c0_dbi <= bus.ramdbi;
                end
            end
        end
    end

    assign bus.ramreq = (r_state == ISSUE);
    assign bus.ramwrt = r_cmd_wrt;
    assign bus.ramadr = r_cmd_adr;
    assign bus.ramdbo = r_cmd_dbo;
    assign bus.c0_ack = (r_state == DONE) && !r_last_grant;
    assign bus.c1_ack = (r_state == DONE) &&  r_last_grant;
    assign bus.c0_dbi = r_c0_dbi;
    assign bus.c1_dbi = r_c1_dbi;
    assign bus.busy   = (r_state != IDLE);

endmodule

// File: tb/tb_scc_ram_arbiter.sv
// tb/tb_scc_ram_arbiter.sv - self-checking bench for scc_ram_arbiter
`timescale 1ns/1ps

module tb_scc_ram_arbiter;
    import scc_ram_arb_pkg::*;

    localparam int L0 = 2;
    localparam int L1 = 1;
    localparam int L2 = 15;

    logic clk21m = 1'b0;
    logic reset  = 1'b1;
    always #23 clk21m = ~clk21m;

    scc_ram_arbiter_if b0 ();
    scc_ram_arbiter_if b1 ();
    scc_ram_arbiter_if b2 ();

    scc_ram_arbiter #(.RAM_LATENCY(L0)) dut0 (.clk21m(clk21m), .reset(reset), .bus(b0.slave));
    scc_ram_arbiter #(.RAM_LATENCY(L1)) dut1 (.clk21m(clk21m), .reset(reset), .bus(b1.slave));
    scc_ram_arbiter #(.RAM_LATENCY(L2)) dut2 (.clk21m(clk21m), .reset(reset), .bus(b2.slave));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk21m) cyc <= cyc + 1;

    typedef struct { int cyc; logic wrt; logic [20:0] adr; logic [7:0] dbo; logic [7:0] data; } rq_t;
    typedef struct { int cyc; int cl; logic [7:0] dbi; logic [20:0] adr; } ack_t;
    typedef struct { logic wrt; logic [20:0] adr; logic [7:0] dbo; } cmd_t;

    rq_t  rq_q[$];
    ack_t ack_q[$];
    cmd_t cq0[$];
    cmd_t cq1[$];
    int   busy_cnt;

    // Reference state: who was served last, and what each client's read-data
    // output must hold.
    int         served_last;
    logic [7:0] exp_dbi [2];

    // RAM models: a fresh byte per access, valid only in the cycle exactly
    // RAM_LATENCY after ramreq; any other cycle carries a different byte.
    int         rem0, rem1, rem2;
    logic [7:0] data0, data1, data2;

    always @(negedge clk21m) begin
        if (b0.ramreq) begin
            data0 = 8'($urandom);
            rem0  = L0;
            rq_q.push_back('{cyc, b0.ramwrt, b0.ramadr, b0.ramdbo, data0});
        end
        if (b0.c0_ack) ack_q.push_back('{cyc, 0, b0.c0_dbi, b0.ramadr});
        if (b0.c1_ack) ack_q.push_back('{cyc, 1, b0.c1_dbi, b0.ramadr});
        if (b0.busy) busy_cnt++;
        if (b1.ramreq) begin data1 = 8'($urandom); rem1 = L1; end
        if (b2.ramreq) begin data2 = 8'($urandom); rem2 = L2; end
    end

    always @(posedge clk21m) begin
        #1;
        b0.ramdbi = (rem0 == 1) ? data0 : (data0 ^ 8'($urandom_range(1, 255)));
        b1.ramdbi = (rem1 == 1) ? data1 : (data1 ^ 8'($urandom_range(1, 255)));
        b2.ramdbi = (rem2 == 1) ? data2 : (data2 ^ 8'($urandom_range(1, 255)));
        if (rem0 > 0) rem0--;
        if (rem1 > 0) rem1--;
        if (rem2 > 0) rem2--;
    end

    task automatic tick();
        @(posedge clk21m);
        #1;
    endtask

    task automatic clear_inputs();
        b0.c0_req = 0; b0.c0_wrt = 0; b0.c0_adr = '0; b0.c0_dbo = '0;
        b0.c1_req = 0; b0.c1_wrt = 0; b0.c1_adr = '0; b0.c1_dbo = '0;
        b1.c0_req = 0; b1.c0_wrt = 0; b1.c0_adr = '0; b1.c0_dbo = '0;
        b1.c1_req = 0; b1.c1_wrt = 0; b1.c1_adr = '0; b1.c1_dbo = '0;
        b2.c0_req = 0; b2.c0_wrt = 0; b2.c0_adr = '0; b2.c0_dbo = '0;
        b2.c1_req = 0; b2.c1_wrt = 0; b2.c1_adr = '0; b2.c1_dbo = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
        served_last = 1;
        exp_dbi[0] = 8'h00;
        exp_dbi[1] = 8'h00;
    endtask

    task automatic clear_logs();
        rq_q.delete();
        ack_q.delete();
        busy_cnt = 0;
    endtask

    // Presents each client's queue front; req stays high while work remains.
    task automatic drive_clients();
        b0.c0_req = (cq0.size() > 0);
        if (cq0.size() > 0) begin
            b0.c0_wrt = cq0[0].wrt; b0.c0_adr = cq0[0].adr; b0.c0_dbo = cq0[0].dbo;
        end
        b0.c1_req = (cq1.size() > 0);
        if (cq1.size() > 0) begin
            b0.c1_wrt = cq1[0].wrt; b0.c1_adr = cq1[0].adr; b0.c1_dbo = cq1[0].dbo;
        end
    endtask

    task automatic run_clients(input int max_cyc);
        int n_ack = ack_q.size();
        int k = 0;
        drive_clients();
        while ((cq0.size() > 0 || cq1.size() > 0) && k < max_cyc) begin
            tick();
            k++;
            while (n_ack < ack_q.size()) begin
                if (ack_q[n_ack].cl == 0 && cq0.size() > 0) void'(cq0.pop_front());
                if (ack_q[n_ack].cl == 1 && cq1.size() > 0) void'(cq1.pop_front());
                n_ack++;
            end
            drive_clients();
        end
        total++;
        if (k >= max_cyc) begin
            bad++;
            $display("FAIL client_timeout left0=%0d left1=%0d required=0", cq0.size(), cq1.size());
            cq0.delete();
            cq1.delete();
            drive_clients();
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [31:0] v [10];
        string nm [10];
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        v  = '{32'(b0.ramreq), 32'(b0.ramwrt), 32'(b0.ramadr), 32'(b0.ramdbo), 32'(b0.c0_ack),
               32'(b0.c1_ack), 32'(b0.c0_dbi), 32'(b0.c1_dbi), 32'(b0.busy), 32'(b2.busy)};
        nm = '{"ramreq", "ramwrt", "ramadr", "ramdbo", "c0_ack", "c1_ack", "c0_dbi", "c1_dbi", "busy", "busy_l15"};
        for (int i = 0; i < 10; i++) begin
            total++;
            if (v[i] !== 32'd0) begin
                bad++;
                $display("FAIL reset_%s got=%0h required=0", nm[i], v[i]);
            end
        end
        apply_reset();
    endtask

    task automatic test_single_read();
        int s;
        clear_logs();
        s = cyc;
        cq0.push_back('{1'b0, 21'h1ABCD, 8'h00});
        run_clients(40);
        total++;
        if (rq_q.size() !== 1) begin bad++; $display("FAIL single_rq_count got=%0d required=1", rq_q.size()); end
        total++;
        if (ack_q.size() !== 1) begin bad++; $display("FAIL single_ack_count got=%0d required=1", ack_q.size()); end
        if (rq_q.size() > 0) begin
            total++;
            if (rq_q[0].cyc !== s + 1) begin bad++; $display("FAIL single_rq_cycle got=%0d required=%0d", rq_q[0].cyc, s + 1); end
            total++;
            if (rq_q[0].adr !== 21'h1ABCD || rq_q[0].wrt !== 1'b0) begin
                bad++; $display("FAIL single_rq_cmd got=%0h/%0b required=1abcd/0", rq_q[0].adr, rq_q[0].wrt);
            end
        end
        if (ack_q.size() > 0 && rq_q.size() > 0) begin
            total++;
            if (ack_q[0].cl !== 0 || ack_q[0].cyc !== s + 2 + L0) begin
                bad++; $display("FAIL single_ack client/cycle got=%0d/%0d required=0/%0d", ack_q[0].cl, ack_q[0].cyc, s + 2 + L0);
            end
            total++;
            if (ack_q[0].dbi !== rq_q[0].data) begin bad++; $display("FAIL single_dbi got=%0h required=%0h", ack_q[0].dbi, rq_q[0].data); end
            exp_dbi[0] = rq_q[0].data;
        end
        total++;
        if (busy_cnt !== L0 + 2) begin bad++; $display("FAIL single_busy_cycles got=%0d required=%0d", busy_cnt, L0 + 2); end
        served_last = 0;
    endtask

    task automatic test_simultaneous();
        logic [20:0] a0;
        apply_reset();
        clear_logs();
        a0 = 21'($urandom) & 21'h0FFFFF;
        cq0.push_back('{1'b0, a0, 8'h00});
        cq1.push_back('{1'b1, 21'h00100, 8'hC3});
        run_clients(60);
        total++;
        if (rq_q.size() !== 2 || ack_q.size() !== 2) begin
            bad++; $display("FAIL simul_counts got=%0d/%0d required=2/2", rq_q.size(), ack_q.size());
        end else begin
            total++;
            if (rq_q[0].adr !== a0 || rq_q[0].wrt !== 1'b0 || ack_q[0].cl !== 0) begin
                bad++; $display("FAIL simul_first got=%0h/%0b/%0d required=%0h/0/0", rq_q[0].adr, rq_q[0].wrt, ack_q[0].cl, a0);
            end
            total++;
            if (rq_q[1].adr !== 21'h00100 || rq_q[1].wrt !== 1'b1 || rq_q[1].dbo !== 8'hC3) begin
                bad++; $display("FAIL simul_c1_write got=%0h/%0b/%0h required=100/1/c3", rq_q[1].adr, rq_q[1].wrt, rq_q[1].dbo);
            end
            total++;
            if (ack_q[1].cl !== 1 || ack_q[1].dbi !== 8'h00) begin
                bad++; $display("FAIL simul_c1_ack got=%0d/%0h required=1/0", ack_q[1].cl, ack_q[1].dbi);
            end
            total++;
            if (ack_q[0].dbi !== rq_q[0].data) begin bad++; $display("FAIL simul_c0_dbi got=%0h required=%0h", ack_q[0].dbi, rq_q[0].data); end
            exp_dbi[0] = rq_q[0].data;
        end
        total++;
        if (b0.c1_dbi !== 8'h00) begin bad++; $display("FAIL simul_c1_dbi_hold got=%0h required=0", b0.c1_dbi); end
        served_last = 1;
    endtask

    task automatic test_back_to_back();
        cmd_t e0 [3];
        cmd_t e1 [3];
        int   ord [6];
        cmd_t ec;
        int   p0 = 3, p1 = 3, last = served_last, i0 = 0, i1 = 0, s;
        logic [7:0] want;
        for (int i = 0; i < 3; i++) begin
            e0[i] = '{1'($urandom), 21'($urandom) & 21'h0FFFFF, 8'($urandom)};
            e1[i] = '{1'($urandom), 21'($urandom) | 21'h100000, 8'($urandom)};
            cq0.push_back(e0[i]);
            cq1.push_back(e1[i]);
        end
        for (int i = 0; i < 6; i++) begin
            if (p0 > 0 && p1 > 0) ord[i] = 1 - last;
            else ord[i] = (p0 > 0) ? 0 : 1;
            if (ord[i] == 0) p0--; else p1--;
            last = ord[i];
        end
        clear_logs();
        s = cyc;
        run_clients(120);
        total++;
        if (rq_q.size() !== 6 || ack_q.size() !== 6) begin
            bad++; $display("FAIL b2b_counts got=%0d/%0d required=6/6", rq_q.size(), ack_q.size());
            return;
        end
        for (int i = 0; i < 6; i++) begin
            if (ord[i] == 0) begin ec = e0[i0]; i0++; end else begin ec = e1[i1]; i1++; end
            total++;
            if (ack_q[i].cl !== ord[i]) begin bad++; $display("FAIL b2b_grant[%0d] got=%0d required=%0d", i, ack_q[i].cl, ord[i]); end
            total++;
            if (rq_q[i].adr !== ec.adr || rq_q[i].wrt !== ec.wrt || (ec.wrt && rq_q[i].dbo !== ec.dbo)) begin
                bad++; $display("FAIL b2b_cmd[%0d] got=%0h/%0b/%0h required=%0h/%0b/%0h", i,
                                rq_q[i].adr, rq_q[i].wrt, rq_q[i].dbo, ec.adr, ec.wrt, ec.dbo);
            end
            total++;
            if (rq_q[i].cyc !== ((i == 0) ? s + 1 : rq_q[i-1].cyc + L0 + 3)) begin
                bad++; $display("FAIL b2b_spacing[%0d] got=%0d required=%0d", i, rq_q[i].cyc, (i == 0) ? s + 1 : rq_q[i-1].cyc + L0 + 3);
            end
            total++;
            if (ack_q[i].cyc !== rq_q[i].cyc + L0 + 1) begin
                bad++; $display("FAIL b2b_ack_cycle[%0d] got=%0d required=%0d", i, ack_q[i].cyc, rq_q[i].cyc + L0 + 1);
            end
            if (!ec.wrt) exp_dbi[ord[i]] = rq_q[i].data;
            want = exp_dbi[ord[i]];
            total++;
            if (ack_q[i].dbi !== want) begin bad++; $display("FAIL b2b_dbi[%0d] got=%0h required=%0h", i, ack_q[i].dbi, want); end
        end
        served_last = ord[5];
    endtask

    task automatic test_drop_midway();
        logic [20:0] a;
        int s;
        clear_logs();
        a = 21'($urandom);
        s = cyc;
        b0.c1_req = 1'b1; b0.c1_wrt = 1'b0; b0.c1_adr = a;
        tick();
        tick();
        b0.c1_req = 1'b0; b0.c1_wrt = 1'b1; b0.c1_adr = ~a;
        repeat (10) tick();
        total++;
        if (rq_q.size() !== 1 || ack_q.size() !== 1) begin
            bad++; $display("FAIL drop_counts got=%0d/%0d required=1/1", rq_q.size(), ack_q.size());
            return;
        end
        total++;
        if (ack_q[0].cl !== 1 || ack_q[0].cyc !== s + 2 + L0) begin
            bad++; $display("FAIL drop_ack got=%0d/%0d required=1/%0d", ack_q[0].cl, ack_q[0].cyc, s + 2 + L0);
        end
        total++;
        if (ack_q[0].adr !== a || rq_q[0].wrt !== 1'b0) begin
            bad++; $display("FAIL drop_cmd_latched got=%0h/%0b required=%0h/0", ack_q[0].adr, rq_q[0].wrt, a);
        end
        total++;
        if (ack_q[0].dbi !== rq_q[0].data) begin bad++; $display("FAIL drop_dbi got=%0h required=%0h", ack_q[0].dbi, rq_q[0].data); end
        exp_dbi[1] = rq_q[0].data;
        served_last = 1;
    endtask

    task automatic test_reset_midway();
        logic [20:0] ax, ay;
        logic [31:0] v;
        clear_logs();
        b0.c0_req = 1'b1; b0.c0_wrt = 1'b0; b0.c0_adr = 21'($urandom) | 21'h1;
        tick();
        tick();
        #5 reset = 1'b1;
        #1;
        v = {26'd0, b0.ramreq, b0.busy, b0.c0_ack, b0.c1_ack, (b0.ramadr != 0), (b0.c0_dbi != 0)};
        total++;
        if (v !== 32'd0) begin bad++; $display("FAIL midreset_outputs got=%0h required=0", v); end
        b0.c0_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        served_last = 1;
        exp_dbi[0] = 8'h00;
        exp_dbi[1] = 8'h00;
        repeat (8) tick();
        total++;
        if (ack_q.size() !== 0 || rq_q.size() !== 1) begin
            bad++; $display("FAIL midreset_no_ack got=%0d/%0d required=0/1", ack_q.size(), rq_q.size());
        end
        clear_logs();
        ax = 21'($urandom) & 21'h0FFFFF;
        ay = 21'($urandom) | 21'h100000;
        cq0.push_back('{1'b0, ax, 8'h00});
        cq1.push_back('{1'b0, ay, 8'h00});
        run_clients(60);
        total++;
        if (rq_q.size() !== 2 || ack_q.size() !== 2) begin
            bad++; $display("FAIL midreset_after_counts got=%0d/%0d required=2/2", rq_q.size(), ack_q.size());
        end else begin
            total++;
            if (rq_q[0].adr !== ax || ack_q[0].cl !== 0) begin
                bad++; $display("FAIL midreset_first_grant got=%0h/%0d required=%0h/0", rq_q[0].adr, ack_q[0].cl, ax);
            end
        end
        served_last = 1;
    endtask

    task automatic test_latency();
        int s, k = 0;
        int n1 = 0, n2 = 0, c1 = -1, c2 = -1;
        logic [7:0] d1 = 8'h00, d2 = 8'h00, w1 = 8'h00, w2 = 8'h00;
        b1.c0_req = 1'b1; b1.c0_wrt = 1'b0; b1.c0_adr = 21'($urandom);
        b2.c0_req = 1'b1; b2.c0_wrt = 1'b0; b2.c0_adr = 21'($urandom);
        s = cyc;
        while (k < 40) begin
            @(negedge clk21m);
            if (b1.c0_ack) begin n1++; c1 = cyc; d1 = b1.c0_dbi; w1 = data1; end
            if (b2.c0_ack) begin n2++; c2 = cyc; d2 = b2.c0_dbi; w2 = data2; end
            tick();
            if (n1 > 0) b1.c0_req = 1'b0;
            if (n2 > 0) b2.c0_req = 1'b0;
            k++;
        end
        total++;
        if (n1 !== 1 || c1 !== s + 2 + L1) begin bad++; $display("FAIL lat1_ack got=%0d@%0d required=1@%0d", n1, c1, s + 2 + L1); end
        total++;
        if (d1 !== w1) begin bad++; $display("FAIL lat1_dbi got=%0h required=%0h", d1, w1); end
        total++;
        if (n2 !== 1 || c2 !== s + 2 + L2) begin bad++; $display("FAIL lat15_ack got=%0d@%0d required=1@%0d", n2, c2, s + 2 + L2); end
        total++;
        if (d2 !== w2) begin bad++; $display("FAIL lat15_dbi got=%0h required=%0h", d2, w2); end
    endtask

    initial begin
        rem0 = 0; rem1 = 0; rem2 = 0;
        data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
        b0.ramdbi = 8'h00; b1.ramdbi = 8'h00; b2.ramdbi = 8'h00;
        busy_cnt = 0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_drop_midway();
        test_reset_midway();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
